// File: rtl/sram_read_ctrl_pkg.sv
// rtl/sram_read_ctrl_pkg.sv - shared supply constants and read FSM state type
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    SENSE,
    LATCH,
    OUT
  } rd_state_e;

endpackage

// File: rtl/sram_read_ctrl_sense_amp.sv
// rtl/sram_read_ctrl_sense_amp.sv - single-column bitline differential comparator
module sense_amp (
  input  real  bl_i,
  input  real  blb_i,
  input  real  vdiff_i,
  output logic bit_o,
  output logic err_o
);

  // A differential smaller than vdiff_i in either direction is unresolved.
  always_comb begin
    bit_o = 1'b0;
    err_o = 1'b0;
    if (bl_i - blb_i >= vdiff_i) begin
      bit_o = 1'b1;
    end else if (!(blb_i - bl_i >= vdiff_i)) begin
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/sram_read_ctrl.sv
// rtl/sram_read_ctrl.sv - SRAM row read sequencer: precharge, sense, latch, valid/ready output
module sram_read_ctrl
  import sram_pkg::*;
#(
  parameter int  ROWS      = 4,
  parameter int  COLS      = 8,
  parameter int  SENSE_CYC = 2,
  parameter real VDIFF     = 0.3,
  localparam int AW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_busy,
  input  real             bl_rd  [0:ROWS-1][0:COLS-1],
  input  real             blb_rd [0:ROWS-1][0:COLS-1],
  output logic [COLS-1:0] rd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic            rd_err
);

  localparam logic [3:0]  SENSE_LAST = 4'(SENSE_CYC - 1);
  localparam logic [AW:0] ROWS_W     = (AW + 1)'(ROWS);

  rd_state_e       state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] data_q, data_d;
  logic            err_q, err_d;
  logic            valid_q, valid_d;

  logic            addr_ok;
  logic [AW-1:0]   row_sel;
  logic [COLS-1:0] col_bit;
  logic [COLS-1:0] col_err;

  assign addr_ok = ({1'b0, rd_addr} < ROWS_W);
  // A rejected address is still latched, so keep the bitline index in range.
  assign row_sel = ({1'b0, addr_q} < ROWS_W) ? addr_q : '0;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    sense_amp u_sense_amp (
      .bl_i    (bl_rd[row_sel][c]),
      .blb_i   (blb_rd[row_sel][c]),
      .vdiff_i (VDIFF),
      .bit_o   (col_bit[c]),
      .err_o   (col_err[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          addr_d = rd_addr;
          if (addr_ok) begin
            state_d = PRECHARGE;
          end else begin
            state_d = OUT;
            data_d  = '0;
            err_d   = 1'b1;
          end
        end
      end
      PRECHARGE: begin
        state_d = SENSE;
        cnt_d   = '0;
      end
      SENSE: begin
        if (cnt_q == SENSE_LAST) begin
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      LATCH: begin
        data_d  = col_bit;
        err_d   = |col_err;
        state_d = OUT;
      end
      OUT: begin
        // valid is registered, so it rises one edge after OUT is entered
        valid_d = 1'b1;
        if (valid_q && rd_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_busy  = (state_q != IDLE);
    rd_valid = valid_q;
    rd_data  = data_q;
    rd_err   = err_q;
  end

endmodule

// File: doc/sram_read_ctrl.md
SRAM_READ_CTRL -- requirements
Module: sram_read_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning the number of memory rows.
REQ-002 SHALL have parameter COLS, default 8, meaning the word width in bits.
REQ-003 SHALL have parameter SENSE_CYC, default 2, meaning the number of sense cycles (legal range 1..15).
REQ-004 SHALL have real parameter VDIFF, default 0.3, meaning the minimum bitline differential in volts.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Port clk: input, 1 bit, the single clock.
REQ-007 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-008 Port rd_req: input, 1 bit, read request.
REQ-009 Port rd_addr: input, $clog2(ROWS) bits, row address.
REQ-010 Port rd_busy: output, 1 bit, high whenever the FSM is not IDLE.
REQ-011 Port bl_rd: input, real [0:ROWS-1][0:COLS-1], per-cell true bitline.
REQ-012 Port blb_rd: input, real [0:ROWS-1][0:COLS-1], per-cell complement bitline.
REQ-013 Port rd_data: output, COLS bits, sensed word.
REQ-014 Port rd_valid: output, 1 bit, rd_data and rd_err are valid.
REQ-015 Port rd_ready: input, 1 bit, consumer accepts the result.
REQ-016 Port rd_err: output, 1 bit, the read had an undetermined column or a bad address.

Function
REQ-017 A request SHALL be accepted on a rising clk edge where state=IDLE and rd_req=1; the accepting edge latches rd_addr internally.
REQ-018 rd_req SHALL be ignored while rd_busy=1.
REQ-019 FSM states SHALL be IDLE, PRECHARGE, SENSE, LATCH, OUT.
REQ-020 Transition IDLE->PRECHARGE SHALL occur on accept with a valid address.
REQ-021 Transition IDLE->OUT SHALL occur on accept when addr>=ROWS, with rd_err=1 and rd_data=0.
REQ-022 PRECHARGE SHALL last exactly 1 cycle, then go to SENSE; entering SENSE SHALL clear the sense counter.
REQ-023 SENSE SHALL last exactly SENSE_CYC cycles, counted by a 4-bit counter, then go to LATCH.
REQ-024 LATCH SHALL last 1 cycle and capture every column of the latched row into rd_data and rd_err, then go to OUT.
REQ-025 Per-column sense SHALL be evaluated as follows:
- bl-blb >= VDIFF gives 1;
- blb-bl >= VDIFF gives 0;
- anything else gives 0 and sets rd_err.
REQ-026 rd_err SHALL be the OR of all column errors.
REQ-027 In OUT, rd_valid SHALL be 1, and rd_data/rd_err SHALL be held stable until rd_ready=1.
REQ-028 OUT->IDLE SHALL occur on an edge with rd_valid=1 and rd_ready=1; rd_valid SHALL fall on that same edge.
REQ-029 Latency: rd_valid SHALL rise SENSE_CYC+3 edges after the accepting edge for a valid address, and 1 edge after it for a bad address.
REQ-030 If rd_ready is already 1 when rd_valid rises, the result SHALL complete after 1 valid cycle.
REQ-031 Bitline changes outside LATCH SHALL NOT affect rd_data.
REQ-032 rd_data and rd_err SHALL retain their last values in IDLE.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, rd_data=0, rd_valid=0, rd_err=0, rd_busy=0, and latched address=0.
REQ-034 A reset during any state SHALL abort the read with no rd_valid pulse, and the first edge after release SHALL be able to accept a request.

Structure
REQ-035 A shared package sram_pkg SHALL hold the constants VDD=1.5, VSS=0.0, VTH=0.8 and the FSM state enum typedef.
REQ-036 The per-column differential comparator SHALL be a sub-module named sense_amp (inputs: two reals and VDIFF; outputs: bit and err), instantiated COLS times via generate.

Verification
REQ-037 Setup: ROWS=4, COLS=8, SENSE_CYC=2. Drive row 2 bitlines to pattern 0xA5 (1.5/0.0 V), then rd_req with addr=2 -> rd_valid rises 5 edges after accept, with rd_data=0xA5 and rd_err=0.
REQ-038 Set column 3 of row 1 to bl=blb=0.75 V and read addr=1 -> bit 3=0 and rd_err=1.
REQ-039 Hold rd_ready=0 for 6 cycles in OUT while toggling the bitlines -> rd_data stays constant and rd_valid stays 1; raising rd_ready gives IDLE on the next edge.
REQ-040 Pulse rd_req again while busy -> the second request is ignored and only one rd_valid pulse occurs.
REQ-041 Assert rst_n=0 during SENSE -> outputs are cleared immediately, no rd_valid occurs, and a read issued right after release returns correct data.
REQ-042 Read with ROWS=3 and addr=3 -> rd_valid 1 edge after accept, with rd_err=1 and rd_data=0.
